// File: rtl/pc_seq_if.sv
// Decoder-to-sequencer op channel: one control-flow op per valid/ready handshake.
interface pc_seq_if #(
    parameter int ADDR_W = 19
);
    logic              op_valid;
    logic              op_ready;
    logic [2:0]        op_code;
    logic [ADDR_W-1:0] op_target;
    logic              zero_flag;

    modport master (output op_valid, op_code, op_target, zero_flag, input op_ready);
    modport slave  (input op_valid, op_code, op_target, zero_flag, output op_ready);
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: step/jump/branch/call/return/halt with an internal
// return-address stack; stack over/underflow parks the block in FAULT until reset.
module pc_sequencer #(
    parameter int ADDR_W    = 19,
    parameter int RAS_DEPTH = 8,
    parameter int RESET_VEC = 0,
    localparam int SP_W     = $clog2(RAS_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    pc_seq_if.slave           op_if,
    input  logic              resume,
    output logic [ADDR_W-1:0] pc,
    output logic              pc_valid,
    output logic              halted,
    output logic              fault,
    output logic [SP_W-1:0]   sp
);
    localparam int IDX_W = $clog2(RAS_DEPTH);

    localparam logic [2:0] OP_JMP  = 3'd1;
    localparam logic [2:0] OP_BEQ  = 3'd2;
    localparam logic [2:0] OP_BNE  = 3'd3;
    localparam logic [2:0] OP_CALL = 3'd4;
    localparam logic [2:0] OP_RET  = 3'd5;
    localparam logic [2:0] OP_HALT = 3'd6;

    typedef enum logic [1:0] {RUN, HALT, FAULT} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc_nxt, pc_inc, ras_top;
    logic [SP_W-1:0]   sp_nxt, sp_dec;
    logic              push, accept;
    logic [ADDR_W-1:0] ras [RAS_DEPTH];

    assign op_if.op_ready = (state == RUN);
    assign pc_valid       = (state != FAULT);
    assign halted         = (state == HALT);
    assign fault          = (state == FAULT);

    assign accept  = op_if.op_valid & op_if.op_ready;
    assign pc_inc  = pc + ADDR_W'(1);
    assign sp_dec  = sp - SP_W'(1);
    assign ras_top = ras[sp_dec[IDX_W-1:0]];

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        sp_nxt    = sp;
        push      = 1'b0;
        case (state)
            RUN: if (accept) begin
                case (op_if.op_code)
                    OP_JMP:  pc_nxt = op_if.op_target;
                    OP_BEQ:  pc_nxt = op_if.zero_flag ? op_if.op_target : pc_inc;
                    OP_BNE:  pc_nxt = op_if.zero_flag ? pc_inc : op_if.op_target;
                    OP_CALL: begin
                        if (sp == SP_W'(RAS_DEPTH)) begin
                            state_nxt = FAULT;
                        end else begin
                            push   = 1'b1;
                            sp_nxt = sp + SP_W'(1);
                            pc_nxt = op_if.op_target;
                        end
                    end
                    OP_RET: begin
                        if (sp == '0) begin
                            state_nxt = FAULT;
                        end else begin
                            sp_nxt = sp_dec;
                            pc_nxt = ras_top;
                        end
                    end
                    OP_HALT: state_nxt = HALT;
                    default: pc_nxt = pc_inc;  // SEQ and reserved code
                endcase
            end
            HALT: if (resume) begin
                state_nxt = RUN;
                pc_nxt    = pc_inc;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            pc    <= ADDR_W'(RESET_VEC);
            sp    <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            sp    <= sp_nxt;
        end
    end

    // Stack contents need no reset: sp alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (push) ras[sp[IDX_W-1:0]] <= pc_inc;
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed test of pc_sequencer: step, jump/wrap, branches, call/return, stack
// overflow/underflow faults, halt/resume and asynchronous reset.
module tb_pc_sequencer;
    localparam int ADDR_W = 19;
    localparam int SP_W   = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              resume = 1'b0;
    logic [ADDR_W-1:0] pc;
    logic              pc_valid, halted, fault;
    logic [SP_W-1:0]   sp;
    int                total = 0;
    int                bad = 0;

    pc_seq_if #(.ADDR_W(ADDR_W)) bus ();

    pc_sequencer #(.ADDR_W(ADDR_W), .RAS_DEPTH(8), .RESET_VEC(0)) dut (
        .clk(clk), .rst_n(rst_n), .op_if(bus), .resume(resume),
        .pc(pc), .pc_valid(pc_valid), .halted(halted), .fault(fault), .sp(sp)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Present one op for one clock edge, then withdraw it; outputs are checked #1 after the edge.
    task automatic op(input logic [2:0] code, input logic [ADDR_W-1:0] tgt, input logic z);
        bus.op_valid  = 1'b1;
        bus.op_code   = code;
        bus.op_target = tgt;
        bus.zero_flag = z;
        @(posedge clk); #1;
        bus.op_valid  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bus.op_valid  = 1'b0;
        bus.op_code   = 3'd0;
        bus.op_target = '0;
        bus.zero_flag = 1'b0;
        do_reset();
        chk("rst_pc", pc, 0);
        chk("rst_sp", sp, 0);
        chk("rst_ready", bus.op_ready, 1);
        chk("rst_pcv", pc_valid, 1);
        chk("rst_halted", halted, 0);
        chk("rst_fault", fault, 0);

        op(3'd0, '0, 0); chk("seq1", pc, 1);
        op(3'd0, '0, 0); chk("seq2", pc, 2);
        op(3'd0, '0, 0); chk("seq3", pc, 3);
        chk("seq_sp", sp, 0);
        @(posedge clk); #1; chk("idle_hold", pc, 3);

        op(3'd1, 19'd450, 0);     chk("jmp450", pc, 450);
        op(3'd1, 19'h7FFFF, 0);   chk("jmp_max", pc, 32'h7FFFF);
        op(3'd0, '0, 0);          chk("wrap", pc, 0);

        op(3'd2, 19'd100, 1);     chk("beq_taken", pc, 100);
        op(3'd3, 19'd200, 1);     chk("bne_nt", pc, 101);
        op(3'd3, 19'd200, 0);     chk("bne_taken", pc, 200);
        op(3'd2, 19'd300, 0);     chk("beq_nt", pc, 201);
        op(3'd7, '0, 0);          chk("rsvd", pc, 202);

        op(3'd1, 19'd10, 0);
        op(3'd4, 19'd450, 0);     chk("call_pc", pc, 450); chk("call_sp", sp, 1);
        op(3'd5, '0, 0);          chk("ret_pc", pc, 11);   chk("ret_sp", sp, 0);
        op(3'd5, '0, 0);
        chk("uf_fault", fault, 1);
        chk("uf_pcv", pc_valid, 0);
        chk("uf_ready", bus.op_ready, 0);
        chk("uf_pc", pc, 11);
        resume = 1'b1;
        op(3'd0, '0, 0);
        resume = 1'b0;
        chk("uf_frozen_pc", pc, 11);
        chk("uf_sticky", fault, 1);

        do_reset();
        chk("rst2_fault", fault, 0);
        for (int i = 1; i <= 8; i++) op(3'd4, ADDR_W'(i * 100), 0);
        chk("nest_sp", sp, 8);
        chk("nest_pc", pc, 800);
        op(3'd5, '0, 0);          chk("lifo_pc", pc, 701); chk("lifo_sp", sp, 7);
        op(3'd4, 19'd800, 0);     chk("refill_sp", sp, 8);
        op(3'd4, 19'd900, 0);
        chk("of_fault", fault, 1);
        chk("of_pc", pc, 800);
        chk("of_sp", sp, 8);

        do_reset();
        op(3'd1, 19'd5, 0);
        op(3'd6, '0, 0);
        chk("halt_flag", halted, 1);
        chk("halt_ready", bus.op_ready, 0);
        chk("halt_pc", pc, 5);
        bus.op_valid = 1'b1;
        bus.op_code  = 3'd1;
        bus.op_target = 19'd77;
        repeat (4) @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        chk("halt_ignore_pc", pc, 5);
        chk("halt_still", halted, 1);
        resume = 1'b1;
        @(posedge clk); #1;
        resume = 1'b0;
        chk("resume_pc", pc, 6);
        chk("resume_ready", bus.op_ready, 1);
        chk("resume_halted", halted, 0);
        resume = 1'b1;
        @(posedge clk); #1;
        resume = 1'b0;
        chk("resume_run_noop", pc, 6);

        op(3'd4, 19'd40, 0);
        op(3'd4, 19'd50, 0);
        chk("chain_sp", sp, 2);
        bus.op_valid  = 1'b1;
        bus.op_code   = 3'd4;
        bus.op_target = 19'd60;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_pc", pc, 0);
        chk("async_sp", sp, 0);
        chk("async_ready", bus.op_ready, 1);
        chk("async_pcv", pc_valid, 1);
        bus.op_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        op(3'd0, '0, 0);
        chk("post_rst_seq", pc, 1);
        chk("post_rst_sp", sp, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
